// File: rtl/hbram_cal_pkg.sv
// Shared types for the HyperBus RAM read-window calibrator: FSM state encoding
// and the width helper used by the per-lane run-length counters.
package hbram_cal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_REQ,
        ST_WAIT,
        ST_EVAL,
        ST_CENTER,
        ST_DONE
    } cal_state_e;

    // Run lengths span 0..STEPS inclusive, hence the +1.
    function automatic int runCntW(input int steps);
        return $clog2(steps + 1);
    endfunction

endpackage

// File: rtl/hbram_cal_window_trk.sv
// One calibration lane: ANDs the per-sample compare results of a tap, tracks the
// current and longest passing tap run, and computes the window centre at sweep end.
module hbram_cal_window_trk
    import hbram_cal_pkg::*;
#(
    parameter int DLY_W = 3,
    parameter int STEPS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             sampleVld_i,
    input  logic             samplePass_i,
    input  logic             eval_i,
    input  logic             lastTap_i,
    input  logic             center_i,
    input  logic [DLY_W-1:0] tap_i,
    output logic [DLY_W-1:0] dly_o,
    output logic             noWin_o,
    output logic             fail_o
);

    localparam int CW = runCntW(STEPS);
    localparam int SW = DLY_W + CW;

    logic             acc_q, acc_d;
    logic             runOpen_q, runOpen_d;
    logic [DLY_W-1:0] runStart_q, runStart_d;
    logic [CW-1:0]    runLen_q, runLen_d;
    logic [DLY_W-1:0] bestStart_q, bestStart_d;
    logic [CW-1:0]    bestLen_q, bestLen_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic             fail_q, fail_d;

    logic [CW-1:0]    runLenInc;
    logic [DLY_W-1:0] candStart;
    logic [CW-1:0]    candLen;
    logic [SW-1:0]    centerSum;

    assign runLenInc = (runLen_q == CW'(STEPS)) ? runLen_q : runLen_q + CW'(1);
    assign candStart = runOpen_q ? runStart_q : tap_i;
    assign candLen   = runOpen_q ? runLenInc : CW'(1);
    assign centerSum = SW'(bestStart_q) + SW'((bestLen_q - CW'(1)) >> 1);

    always_comb begin
        acc_d       = acc_q;
        runOpen_d   = runOpen_q;
        runStart_d  = runStart_q;
        runLen_d    = runLen_q;
        bestStart_d = bestStart_q;
        bestLen_d   = bestLen_q;
        dly_d       = dly_q;
        fail_d      = fail_q;
        if (clear_i) begin
            acc_d       = 1'b1;
            runOpen_d   = 1'b0;
            runStart_d  = '0;
            runLen_d    = '0;
            bestStart_d = '0;
            bestLen_d   = '0;
            dly_d       = '0;
            fail_d      = 1'b0;
        end else begin
            if (sampleVld_i) begin
                acc_d = acc_q & samplePass_i;
            end
            // Strict > keeps the earliest window when two runs tie.
            if (eval_i) begin
                acc_d = 1'b1;
                if (acc_q) begin
                    runOpen_d  = 1'b1;
                    runStart_d = candStart;
                    runLen_d   = candLen;
                    if (lastTap_i) begin
                        runOpen_d = 1'b0;
                        runLen_d  = '0;
                        if (candLen > bestLen_q) begin
                            bestStart_d = candStart;
                            bestLen_d   = candLen;
                        end
                    end
                end else begin
                    runOpen_d = 1'b0;
                    runLen_d  = '0;
                    if (runOpen_q && (runLen_q > bestLen_q)) begin
                        bestStart_d = runStart_q;
                        bestLen_d   = runLen_q;
                    end
                end
            end
            if (center_i) begin
                if (bestLen_q == '0) begin
                    dly_d  = '0;
                    fail_d = 1'b1;
                end else begin
                    dly_d  = centerSum[DLY_W-1:0];
                    fail_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= 1'b1;
            runOpen_q   <= 1'b0;
            runStart_q  <= '0;
            runLen_q    <= '0;
            bestStart_q <= '0;
            bestLen_q   <= '0;
            dly_q       <= '0;
            fail_q      <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            runOpen_q   <= runOpen_d;
            runStart_q  <= runStart_d;
            runLen_q    <= runLen_d;
            bestStart_q <= bestStart_d;
            bestLen_q   <= bestLen_d;
            dly_q       <= dly_d;
            fail_q      <= fail_d;
        end
    end

    assign dly_o   = dly_q;
    assign noWin_o = (bestLen_q == '0);
    assign fail_o  = fail_q;

endmodule

// File: rtl/hbram_window_cal.sv
// HyperBus RAM per-lane delay calibrator: sweeps all taps, requests pattern tests,
// centres each lane in its widest passing window. HBRAM_CAL_RETRY_EN enables re-sweeps.
module hbram_window_cal
    import hbram_cal_pkg::*;
#(
    parameter int LANES      = 8,
    parameter int DLY_W      = 3,
    parameter int STEPS      = 8,
    parameter int SAMPLES    = 4,
    parameter int SETTLE_CYC = 16,
    parameter int MAX_RETRY  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cal_start,
    output logic                   test_req,
    input  logic                   test_ack,
    input  logic [LANES-1:0]       test_pass,
    output logic [LANES*DLY_W-1:0] dly_out,
    output logic                   busy,
    output logic                   cal_done,
    output logic                   cal_fail,
    output logic [LANES-1:0]       fail_mask,
    output logic [1:0]             retry_cnt
);

    localparam int SCW = $clog2(SETTLE_CYC + 1);
    localparam int SMW = $clog2(SAMPLES + 1);

    cal_state_e       state_q, state_d;
    logic [SCW-1:0]   settleCnt_q, settleCnt_d;
    logic [SMW-1:0]   sampleCnt_q, sampleCnt_d;
    logic [DLY_W-1:0] tap_q, tap_d;
    logic             testReq_q, testReq_d;
    logic             busy_q, busy_d;
    logic             calDone_q, calDone_d;
    logic             calFail_q, calFail_d;
    logic             useCenter_q, useCenter_d;
`ifdef HBRAM_CAL_RETRY_EN
    logic [1:0]       retryCnt_q, retryCnt_d;
`endif

    logic             clearTrk, sampleVld, evalPulse, centerPulse, lastTap, anyNoWin;
    logic [DLY_W-1:0] trkDly [LANES];
    logic [LANES-1:0] noWin;

    assign lastTap  = (tap_q == DLY_W'(STEPS - 1));
    assign anyNoWin = |noWin;

    always_comb begin
        state_d     = state_q;
        settleCnt_d = '0;
        sampleCnt_d = sampleCnt_q;
        tap_d       = tap_q;
        testReq_d   = testReq_q;
        busy_d      = busy_q;
        calDone_d   = calDone_q;
        calFail_d   = calFail_q;
        useCenter_d = useCenter_q;
`ifdef HBRAM_CAL_RETRY_EN
        retryCnt_d  = retryCnt_q;
`endif
        clearTrk    = 1'b0;
        sampleVld   = 1'b0;
        evalPulse   = 1'b0;
        centerPulse = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (cal_start) begin
                    state_d     = ST_SETTLE;
                    clearTrk    = 1'b1;
                    tap_d       = '0;
                    sampleCnt_d = '0;
                    busy_d      = 1'b1;
                    calDone_d   = 1'b0;
                    calFail_d   = 1'b0;
                    useCenter_d = 1'b0;
`ifdef HBRAM_CAL_RETRY_EN
                    retryCnt_d  = '0;
`endif
                end
            end
            ST_SETTLE: begin
                if (settleCnt_q == SCW'(SETTLE_CYC - 1)) begin
                    state_d = ST_REQ;
                end else begin
                    settleCnt_d = settleCnt_q + SCW'(1);
                end
            end
            ST_REQ: begin
                testReq_d = 1'b1;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (test_ack) begin
                    sampleVld = 1'b1;
                    testReq_d = 1'b0;
                    if (sampleCnt_q == SMW'(SAMPLES - 1)) begin
                        sampleCnt_d = '0;
                        state_d     = ST_EVAL;
                    end else begin
                        sampleCnt_d = sampleCnt_q + SMW'(1);
                        state_d     = ST_REQ;
                    end
                end
            end
            ST_EVAL: begin
                evalPulse = 1'b1;
                if (lastTap) begin
                    state_d = ST_CENTER;
                end else begin
                    tap_d   = tap_q + DLY_W'(1);
                    state_d = ST_SETTLE;
                end
            end
            ST_CENTER: begin
                centerPulse = 1'b1;
                state_d     = ST_DONE;
                busy_d      = 1'b0;
                calDone_d   = 1'b1;
                calFail_d   = anyNoWin;
                useCenter_d = 1'b1;
`ifdef HBRAM_CAL_RETRY_EN
                // A dead lane triggers a fresh sweep until the retry budget is spent.
                if (anyNoWin && (retryCnt_q < 2'(MAX_RETRY))) begin
                    state_d     = ST_SETTLE;
                    busy_d      = 1'b1;
                    calDone_d   = 1'b0;
                    calFail_d   = 1'b0;
                    useCenter_d = 1'b0;
                    clearTrk    = 1'b1;
                    tap_d       = '0;
                    retryCnt_d  = retryCnt_q + 2'd1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            settleCnt_q <= '0;
            sampleCnt_q <= '0;
            tap_q       <= '0;
            testReq_q   <= 1'b0;
            busy_q      <= 1'b0;
            calDone_q   <= 1'b0;
            calFail_q   <= 1'b0;
            useCenter_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            settleCnt_q <= settleCnt_d;
            sampleCnt_q <= sampleCnt_d;
            tap_q       <= tap_d;
            testReq_q   <= testReq_d;
            busy_q      <= busy_d;
            calDone_q   <= calDone_d;
            calFail_q   <= calFail_d;
            useCenter_q <= useCenter_d;
        end
    end

`ifdef HBRAM_CAL_RETRY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            retryCnt_q <= '0;
        end else begin
            retryCnt_q <= retryCnt_d;
        end
    end
    assign retry_cnt = retryCnt_q;
`else
    assign retry_cnt = 2'b00;
`endif

    // During the sweep every lane sees the common tap; afterwards its own centre.
    for (genvar g = 0; g < LANES; g++) begin : gLane
        hbram_cal_window_trk #(
            .DLY_W (DLY_W),
            .STEPS (STEPS)
        ) uTrk (
            .clk          (clk),
            .rst          (rst),
            .clear_i      (clearTrk),
            .sampleVld_i  (sampleVld),
            .samplePass_i (test_pass[g]),
            .eval_i       (evalPulse),
            .lastTap_i    (lastTap),
            .center_i     (centerPulse),
            .tap_i        (tap_q),
            .dly_o        (trkDly[g]),
            .noWin_o      (noWin[g]),
            .fail_o       (fail_mask[g])
        );
        assign dly_out[g*DLY_W +: DLY_W] = useCenter_q ? trkDly[g] : tap_q;
    end

    assign test_req = testReq_q;
    assign busy     = busy_q;
    assign cal_done = calDone_q;
    assign cal_fail = calFail_q;

endmodule
